ddr3_port_arbiter: RTL and testbench

DDR3_PORT_ARBITER -- requirements
Module: ddr3_port_arbiter

---
 rtl/ddr3_port_arbiter.sv | 163 ++++++++++++++++
 tb/tb_ddr3_port_arbiter.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr3_port_arbiter.sv
// Two-port (video-in write / video-out read) arbiter in front of a DDR3 controller, one command outstanding.
// Optional starvation guard enabled by defining ARB_STARVE_GUARD_EN.
module ddr3_port_arbiter #(
  parameter int unsigned AW         = 28,
  parameter int unsigned LW         = 8,
  parameter int unsigned STARVE_MAX = 255
) (
  input  logic          core_clk,
  input  logic          rst,
  input  logic          wr_req,
  input  logic [AW-1:0] wr_addr,
  input  logic [LW-1:0] wr_len,
  input  logic          rd_req,
  input  logic [AW-1:0] rd_addr,
  input  logic [LW-1:0] rd_len,
  input  logic          rd_urgent,
  output logic          wr_gnt,
  output logic          rd_gnt,
  output logic          wr_done,
  output logic          rd_done,
  output logic          cmd_valid,
  input  logic          cmd_ready,
  output logic          cmd_we,
  output logic [AW-1:0] cmd_addr,
  output logic [LW-1:0] cmd_len,
  input  logic          cmd_done,
  output logic          busy
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;

  logic [1:0]    state_q, state_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [LW-1:0] len_q, len_d;
  logic          last_wr_q, last_wr_d;
  logic          wr_done_q, wr_done_d;
  logic          rd_done_q, rd_done_d;
  logic          wr_exp, rd_exp;
  logic          pick_wr;

`ifdef ARB_STARVE_GUARD_EN
  localparam int unsigned CW = (STARVE_MAX < 2) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(STARVE_MAX);

  logic [CW-1:0] wr_cnt_q, wr_cnt_d;
  logic [CW-1:0] rd_cnt_q, rd_cnt_d;
  logic          wr_owned, rd_owned;

  // A port only ages while it waits behind the other port's command or in IDLE.
  always_comb begin
    wr_owned = (state_q != ST_IDLE) && we_q;
    rd_owned = (state_q != ST_IDLE) && !we_q;
    wr_cnt_d = wr_cnt_q;
    rd_cnt_d = rd_cnt_q;
    if (wr_gnt) begin
      wr_cnt_d = '0;
    end else if (wr_req && !wr_owned && (wr_cnt_q != CNT_MAX)) begin
      wr_cnt_d = wr_cnt_q + 1'b1;
    end
    if (rd_gnt) begin
      rd_cnt_d = '0;
    end else if (rd_req && !rd_owned && (rd_cnt_q != CNT_MAX)) begin
      rd_cnt_d = rd_cnt_q + 1'b1;
    end
    wr_exp = wr_req && (wr_cnt_q == CNT_MAX);
    rd_exp = rd_req && (rd_cnt_q == CNT_MAX);
  end

  always_ff @(posedge core_clk) begin
    if (rst) begin
      wr_cnt_q <= '0;
      rd_cnt_q <= '0;
    end else begin
      wr_cnt_q <= wr_cnt_d;
      rd_cnt_q <= rd_cnt_d;
    end
  end
`else
  assign wr_exp = 1'b0;
  assign rd_exp = 1'b0;
`endif

  always_comb begin
    if (wr_exp != rd_exp) begin
      pick_wr = wr_exp;
    end else if (wr_exp) begin
      pick_wr = !last_wr_q;
    end else if (rd_req && rd_urgent) begin
      pick_wr = 1'b0;
    end else if (wr_req != rd_req) begin
      pick_wr = wr_req;
    end else begin
      pick_wr = !last_wr_q;
    end
  end

  always_comb begin
    state_d   = state_q;
    we_d      = we_q;
    addr_d    = addr_q;
    len_d     = len_q;
    last_wr_d = last_wr_q;
    wr_done_d = 1'b0;
    rd_done_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (wr_req || rd_req) begin
          we_d    = pick_wr;
          addr_d  = pick_wr ? wr_addr : rd_addr;
          len_d   = pick_wr ? wr_len : rd_len;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (cmd_ready) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (cmd_done) begin
          wr_done_d = we_q;
          rd_done_d = !we_q;
          last_wr_d = we_q;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge core_clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      we_q      <= 1'b0;
      addr_q    <= '0;
      len_q     <= '0;
      last_wr_q <= 1'b0;
      wr_done_q <= 1'b0;
      rd_done_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      len_q     <= len_d;
      last_wr_q <= last_wr_d;
      wr_done_q <= wr_done_d;
      rd_done_q <= rd_done_d;
    end
  end

  // Outputs are forced low during reset so they are 0 even before the first reset edge.
  assign cmd_valid = !rst && (state_q == ST_ISSUE);
  assign wr_gnt    = cmd_valid && cmd_ready && we_q;
  assign rd_gnt    = cmd_valid && cmd_ready && !we_q;
  assign cmd_we    = !rst && we_q;
  assign cmd_addr  = rst ? '0 : addr_q;
  assign cmd_len   = rst ? '0 : len_q;
  assign wr_done   = !rst && wr_done_q;
  assign rd_done   = !rst && rd_done_q;
  assign busy      = !rst && (state_q != ST_IDLE);

endmodule

// File: tb/tb_ddr3_port_arbiter.sv
// Self-checking bench for ddr3_port_arbiter: directed scenarios plus randomized traffic against a transaction-level model.
module tb_ddr3_port_arbiter;
  localparam int AW   = 28;
  localparam int LW   = 8;
  localparam int SMAX = 8;

  logic          core_clk = 1'b0;
  logic          rst, wr_req, rd_req, rd_urgent, cmd_ready, cmd_done;
  logic [AW-1:0] wr_addr, rd_addr, cmd_addr;
  logic [LW-1:0] wr_len, rd_len, cmd_len;
  logic          wr_gnt, rd_gnt, wr_done, rd_done, cmd_valid, cmd_we, busy;

  always #5 core_clk = ~core_clk;

  ddr3_port_arbiter #(.AW(AW), .LW(LW), .STARVE_MAX(SMAX)) dut (
    .core_clk(core_clk), .rst(rst),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_len(wr_len),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_len(rd_len),
    .rd_urgent(rd_urgent),
    .wr_gnt(wr_gnt), .rd_gnt(rd_gnt), .wr_done(wr_done), .rd_done(rd_done),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_done(cmd_done), .busy(busy)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] out_vec();
    return {20'd0, wr_gnt, rd_gnt, wr_done, rd_done, cmd_valid, cmd_we, busy, cmd_addr, cmd_len, 1'b0};
  endfunction

  task automatic step();
    @(posedge core_clk);
    #1;
  endtask

  // Transaction-level model: an optional command that is either waiting for acceptance or in flight.
  bit            chk_en = 0;
  bit            m_busy, m_acc, m_wr, m_last_wr, m_wdone, m_rdone;
  logic [AW-1:0] m_addr;
  logic [LW-1:0] m_len;
  int            m_wcnt, m_rcnt;

  function automatic bit pick_write();
    bit wexp, rexp;
    wexp = 0;
    rexp = 0;
`ifdef ARB_STARVE_GUARD_EN
    wexp = wr_req && (m_wcnt == SMAX);
    rexp = rd_req && (m_rcnt == SMAX);
`endif
    if (wexp && rexp) return !m_last_wr;
    if (wexp) return 1'b1;
    if (rexp) return 1'b0;
    if (rd_req && rd_urgent) return 1'b0;
    if (wr_req && !rd_req) return 1'b1;
    if (rd_req && !wr_req) return 1'b0;
    return !m_last_wr;
  endfunction

  always @(posedge core_clk) begin
    bit g_w, g_r, p;
    if (rst) begin
      m_busy = 0; m_acc = 0; m_wr = 0; m_last_wr = 0;
      m_wdone = 0; m_rdone = 0; m_wcnt = 0; m_rcnt = 0;
      chk_en = 1;
    end else begin
      g_w = m_busy && !m_acc && cmd_ready && m_wr;
      g_r = m_busy && !m_acc && cmd_ready && !m_wr;
      p   = pick_write();
      if (g_w) m_wcnt = 0;
      else if (wr_req && !(m_busy && m_wr) && m_wcnt < SMAX) m_wcnt++;
      if (g_r) m_rcnt = 0;
      else if (rd_req && !(m_busy && !m_wr) && m_rcnt < SMAX) m_rcnt++;
      m_wdone = 0;
      m_rdone = 0;
      if (!m_busy) begin
        if (wr_req || rd_req) begin
          m_wr   = p;
          m_addr = p ? wr_addr : rd_addr;
          m_len  = p ? wr_len : rd_len;
          m_busy = 1;
          m_acc  = 0;
        end
      end else if (!m_acc) begin
        if (cmd_ready) m_acc = 1;
      end else if (cmd_done) begin
        if (m_wr) m_wdone = 1;
        else m_rdone = 1;
        m_last_wr = m_wr;
        m_busy    = 0;
      end
    end
  end

  always @(negedge core_clk) begin
    bit ev;
    if (chk_en) begin
      if (rst) begin
        chk("m_reset_zero", out_vec(), 64'd0);
      end else begin
        ev = m_busy && !m_acc;
        chk("m_cmd_valid", cmd_valid, ev);
        chk("m_busy", busy, m_busy);
        chk("m_wr_gnt", wr_gnt, ev && cmd_ready && m_wr);
        chk("m_rd_gnt", rd_gnt, ev && cmd_ready && !m_wr);
        chk("m_wr_done", wr_done, m_wdone);
        chk("m_rd_done", rd_done, m_rdone);
        if (ev) begin
          chk("m_cmd_we", cmd_we, m_wr);
          chk("m_cmd_addr", cmd_addr, m_addr);
          chk("m_cmd_len", cmd_len, m_len);
        end
      end
    end
  end

  task automatic serve(input bit exp_wr, input string name);
    bit got;
    got = 0;
    for (int i = 0; i < 12 && !got; i++) begin
      @(negedge core_clk);
      if (wr_gnt || rd_gnt) got = 1;
      else step();
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL %s: got no grant expected grant within 12 cycles", name);
    end else begin
      chk({name, "_wr"}, wr_gnt, exp_wr);
      chk({name, "_rd"}, rd_gnt, !exp_wr);
    end
    step();
    step();
    cmd_done = 1;
    step();
    cmd_done = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit got;
    rst = 1; wr_req = 0; rd_req = 0; rd_urgent = 0; cmd_ready = 0; cmd_done = 0;
    wr_addr = '0; rd_addr = '0; wr_len = '0; rd_len = '0;
    repeat (3) step();
    @(negedge core_clk);
    chk("reset_outputs", out_vec(), 64'd0);
    rst = 0;
    step();

    // Single write burst, cycle N starts here.
    wr_req = 1; wr_addr = 28'h100; wr_len = 8'd15; cmd_ready = 1;
    @(negedge core_clk);
    chk("w_idle_valid", cmd_valid, 0);
    step();
    @(negedge core_clk);
    chk("w_valid", cmd_valid, 1);
    chk("w_we", cmd_we, 1);
    chk("w_addr", cmd_addr, 64'h100);
    chk("w_len", cmd_len, 64'd15);
    chk("w_gnt", wr_gnt, 1);
    chk("w_rd_gnt", rd_gnt, 0);
    step();
    wr_req = 0;
    @(negedge core_clk);
    chk("w_wait_busy", busy, 1);
    chk("w_wait_valid", cmd_valid, 0);
    repeat (18) step();
    cmd_done = 1;
    @(negedge core_clk);
    chk("w_done_early", wr_done, 0);
    step();
    cmd_done = 0;
    @(negedge core_clk);
    chk("w_done", wr_done, 1);
    chk("w_idle_busy", busy, 0);
    step();
    @(negedge core_clk);
    chk("w_done_pulse", wr_done, 0);

    // Tie after reset, alternation, urgent read.
    rst = 1;
    step();
    step();
    rst = 0; wr_req = 1; rd_req = 1; wr_addr = 28'h0AA0; rd_addr = 28'h0BB0; wr_len = 8'd3; rd_len = 8'd5;
    serve(1, "tie1");
    serve(0, "tie2");
    serve(1, "tie3");
    serve(0, "tie4");
    rd_urgent = 1;
    serve(0, "urgent");
    rd_urgent = 0;
    serve(1, "after_urgent");
    wr_req = 0; rd_req = 0;
    step();
    step();

    // Back-pressure on the read port.
    cmd_ready = 0; rd_req = 1; rd_addr = 28'h2A0; rd_len = 8'd7;
    step();
    for (int i = 0; i < 5; i++) begin
      @(negedge core_clk);
      chk("bp_valid", cmd_valid, 1);
      chk("bp_addr", cmd_addr, 64'h2A0);
      chk("bp_len", cmd_len, 64'd7);
      chk("bp_no_gnt", rd_gnt, 0);
      step();
    end
    cmd_ready = 1;
    @(negedge core_clk);
    chk("bp_gnt", rd_gnt, 1);
    step();
    rd_req = 0; cmd_done = 1;
    step();
    cmd_done = 0;
    @(negedge core_clk);
    chk("bp_done", rd_done, 1);

    // Reset while waiting for completion.
    step();
    wr_req = 1; wr_addr = 28'h55; wr_len = 8'd1;
    step();
    wr_req = 0;
    step();
    @(negedge core_clk);
    chk("rw_in_wait", busy, 1);
    rst = 1;
    @(negedge core_clk);
    chk("rw_rst_zero", out_vec(), 64'd0);
    step();
    rst = 0; cmd_done = 1;
    step();
    cmd_done = 0;
    @(negedge core_clk);
    chk("rw_no_done", out_vec(), 64'd0);

`ifdef ARB_STARVE_GUARD_EN
    // Urgent reads back-to-back; the write must eventually break through.
    rst = 1;
    step();
    rst = 0; wr_req = 1; rd_req = 1; rd_urgent = 1; cmd_ready = 1; cmd_done = 1;
    got = 0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge core_clk);
      if (wr_gnt) got = 1;
      else step();
    end
    chk("guard_wr_gnt", got, 1);
    step();
    wr_req = 0; rd_req = 0; rd_urgent = 0; cmd_done = 0;
    step();
`endif

    for (int n = 0; n < 3000; n++) begin
      step();
      rst       = ($urandom_range(199) == 0);
      wr_req    = ($urandom_range(3) != 0);
      rd_req    = ($urandom_range(3) != 0);
      rd_urgent = ($urandom_range(4) == 0);
      cmd_ready = ($urandom_range(9) < 7);
      cmd_done  = ($urandom_range(4) == 0);
      wr_addr   = AW'($urandom);
      rd_addr   = AW'($urandom);
      wr_len    = LW'($urandom);
      rd_len    = LW'($urandom);
    end
    step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
